// File: rtl/digit_clock_if.sv
// Key inputs and display-path outputs of the time-of-day controller.
// The master side drives the keys; the slave side is the controller.
interface digit_clock_if;
  logic       key_mode;
  logic       key_run;
  logic       key_inc;
  logic [3:0] cout1;
  logic [3:0] cout2;
  logic [3:0] cout3;
  logic [3:0] cout4;
  logic [3:0] cout5;
  logic [3:0] cout6;
  logic [5:0] blank;
  logic       tick;
  logic [2:0] state;

  modport master (
    output key_mode, key_run, key_inc,
    input  cout1, cout2, cout3, cout4, cout5, cout6, blank, tick, state
  );

  modport slave (
    input  key_mode, key_run, key_inc,
    output cout1, cout2, cout3, cout4, cout5, cout6, blank, tick, state
  );
endinterface

// File: rtl/digit_clock_ctrl.sv
// HH:MM:SS BCD time-of-day counter with run/pause/set modes, 1 Hz prescaler
// and a blink mask for the field being set.
module digit_clock_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic         clk,
  input  logic         rst,
  digit_clock_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(TICK_DIV / 2);

  typedef enum logic [2:0] {
    RUN = 3'd0, PAUSE = 3'd1, SET_HOUR = 3'd2, SET_MIN = 3'd3, SET_SEC = 3'd4
  } mode_e;

  mode_e         state_q, state_d;
  logic [PW-1:0] presc_q, presc_d, presc_nxt;
  logic [3:0]    s1_q, s10_q, m1_q, m10_q, h1_q, h10_q;
  logic [3:0]    s1_d, s10_d, m1_d, m10_d, h1_d, h10_d;
  logic          kmode_q, krun_q, kinc_q;
  logic          tick_q, tick_d;
  logic [5:0]    blank_q, blank_d;
  logic          p_mode, p_run, p_inc, wrap, adv, half;

  // Two-digit BCD increment, 59 -> 00
  function automatic logic [7:0] inc60(input logic [3:0] t, input logic [3:0] o);
    if (o == 4'd9) inc60 = {(t == 4'd5) ? 4'd0 : t + 4'd1, 4'd0};
    else           inc60 = {t, o + 4'd1};
  endfunction

  // Two-digit BCD increment, 23 -> 00
  function automatic logic [7:0] inc24(input logic [3:0] t, input logic [3:0] o);
    if (t == 4'd2 && o == 4'd3) inc24 = 8'h00;
    else if (o == 4'd9)         inc24 = {t + 4'd1, 4'd0};
    else                        inc24 = {t, o + 4'd1};
  endfunction

  always_comb begin
    p_mode    = bus.key_mode & ~kmode_q;
    p_run     = bus.key_run & ~krun_q & ~p_mode;
    p_inc     = bus.key_inc & ~kinc_q & ~p_mode & ~p_run;
    wrap      = (presc_q == P_LAST);
    presc_nxt = wrap ? '0 : presc_q + 1'b1;
    state_d   = state_q;
    presc_d   = presc_q;
    adv       = 1'b0;
    {s10_d, s1_d} = {s10_q, s1_q};
    {m10_d, m1_d} = {m10_q, m1_q};
    {h10_d, h1_d} = {h10_q, h1_q};

    if (p_mode) begin
      case (state_q)
        SET_HOUR: begin state_d = SET_MIN;  presc_d = presc_nxt; end
        SET_MIN:  begin state_d = SET_SEC;  presc_d = presc_nxt; end
        SET_SEC:  begin state_d = RUN;      presc_d = '0;        end
        default:  begin state_d = SET_HOUR; presc_d = '0;        end
      endcase
    end else if (p_run && (state_q == RUN || state_q == PAUSE)) begin
      // Toggle leaves the prescaler untouched so a resume continues mid-second
      state_d = (state_q == RUN) ? PAUSE : RUN;
    end else if (p_inc && state_q != RUN && state_q != PAUSE) begin
      presc_d = '0;
      case (state_q)
        SET_HOUR: {h10_d, h1_d} = inc24(h10_q, h1_q);
        SET_MIN:  {m10_d, m1_d} = inc60(m10_q, m1_q);
        default:  {s10_d, s1_d} = inc60(s10_q, s1_q);
      endcase
    end else if (state_q != PAUSE) begin
      presc_d = presc_nxt;
      adv     = (state_q == RUN) && wrap;
    end

    if (adv) begin
      {s10_d, s1_d} = inc60(s10_q, s1_q);
      if ({s10_q, s1_q} == 8'h59) begin
        {m10_d, m1_d} = inc60(m10_q, m1_q);
        if ({m10_q, m1_q} == 8'h59) {h10_d, h1_d} = inc24(h10_q, h1_q);
      end
    end
    tick_d = adv;

    // Blank is built from next-state values so it lines up with the prescaler
    half    = (presc_d >= P_HALF);
    blank_d = '0;
    case (state_d)
      SET_HOUR: blank_d[5:4] = {2{half}};
      SET_MIN:  blank_d[3:2] = {2{half}};
      SET_SEC:  blank_d[1:0] = {2{half}};
      default:  blank_d      = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      presc_q <= '0;
      {s1_q, s10_q, m1_q, m10_q, h1_q, h10_q} <= '0;
      {kmode_q, krun_q, kinc_q} <= '0;
      tick_q  <= 1'b0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      {s1_q, s10_q, m1_q, m10_q, h1_q, h10_q} <= {s1_d, s10_d, m1_d, m10_d, h1_d, h10_d};
      {kmode_q, krun_q, kinc_q} <= {bus.key_mode, bus.key_run, bus.key_inc};
      tick_q  <= tick_d;
      blank_q <= blank_d;
    end
  end

  assign bus.cout1 = s1_q;
  assign bus.cout2 = s10_q;
  assign bus.cout3 = m1_q;
  assign bus.cout4 = m10_q;
  assign bus.cout5 = h1_q;
  assign bus.cout6 = h10_q;
  assign bus.blank = blank_q;
  assign bus.tick  = tick_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_digit_clock_ctrl.sv
// Bench for digit_clock_ctrl: directed scenarios plus random key traffic,
// checked against a seconds-of-day reference model.
module tb_digit_clock_ctrl;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  digit_clock_if bus ();

  digit_clock_ctrl #(.TICK_DIV(TD)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: time as seconds since midnight
  int         m_sec, m_mode, m_presc;
  bit         pk_m, pk_r, pk_i, m_tick;
  logic [5:0] m_blank;

  task automatic model_reset();
    m_sec = 0; m_mode = 0; m_presc = 0;
    pk_m = 0; pk_r = 0; pk_i = 0; m_tick = 0; m_blank = '0;
  endtask

  task automatic model_edge(input bit km, input bit kr, input bit ki);
    bit pm, pr, pi;
    int h, mi, s;
    pm = km && !pk_m;
    pr = kr && !pk_r && !pm;
    pi = ki && !pk_i && !pm && !pr;
    h = m_sec / 3600; mi = (m_sec / 60) % 60; s = m_sec % 60;
    m_tick = 0;
    if (pm) begin
      if (m_mode <= 1)      begin m_mode = 2; m_presc = 0; end
      else if (m_mode == 4) begin m_mode = 0; m_presc = 0; end
      else begin m_mode = m_mode + 1; m_presc = (m_presc + 1) % TD; end
    end else if (pr && m_mode <= 1) begin
      m_mode = 1 - m_mode;
    end else if (pi && m_mode >= 2) begin
      if (m_mode == 2)      h  = (h + 1) % 24;
      else if (m_mode == 3) mi = (mi + 1) % 60;
      else                  s  = (s + 1) % 60;
      m_sec = h * 3600 + mi * 60 + s;
      m_presc = 0;
    end else if (m_mode != 1) begin
      if (m_mode == 0 && m_presc == TD - 1) begin
        m_sec = (m_sec + 1) % 86400;
        m_tick = 1;
      end
      m_presc = (m_presc + 1) % TD;
    end
    m_blank = '0;
    if (m_mode >= 2 && m_presc >= TD / 2) m_blank = 6'b000011 << (2 * (4 - m_mode));
    pk_m = km; pk_r = kr; pk_i = ki;
  endtask

  function automatic logic [7:0] bcd2(input int v);
    bcd2 = {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [33:0] exp_vec();
    exp_vec = {bcd2(m_sec / 3600), bcd2((m_sec / 60) % 60), bcd2(m_sec % 60),
               m_blank, m_tick, 3'(m_mode)};
  endfunction

  function automatic logic [33:0] obs_vec();
    obs_vec = {bus.cout6, bus.cout5, bus.cout4, bus.cout3, bus.cout2, bus.cout1,
               bus.blank, bus.tick, bus.state};
  endfunction

  task automatic check_all(input string tag);
    n_assert++;
    assert (obs_vec() === exp_vec()) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs_vec(), exp_vec());
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input bit km, input bit kr, input bit ki);
    bus.key_mode = km; bus.key_run = kr; bus.key_inc = ki;
    @(posedge clk);
    model_edge(km, kr, ki);
    #1;
    check_all("cycle");
  endtask

  task automatic press(input bit km, input bit kr, input bit ki);
    step(km, kr, ki);
    step(0, 0, 0);
  endtask

  logic [7:0]  h0;
  logic [23:0] digs;

  initial begin
    bus.key_mode = 0; bus.key_run = 0; bus.key_inc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // Free run from reset
    repeat (4) step(0, 0, 0);
    check_val("first_adv_cout1", 32'(bus.cout1), 32'd1);
    check_val("first_adv_tick", 32'(bus.tick), 32'd1);
    step(0, 0, 0);
    check_val("tick_one_cycle", 32'(bus.tick), 32'd0);
    repeat (35) step(0, 0, 0);
    check_val("ten_seconds", 32'({bus.cout2, bus.cout1}), 32'h10);

    // Rollover from 23:59:59
    press(1, 0, 0);
    while (m_sec / 3600 != 23) press(0, 0, 1);
    press(1, 0, 0);
    while ((m_sec / 60) % 60 != 59) press(0, 0, 1);
    press(1, 0, 0);
    while (m_sec % 60 != 59) press(0, 0, 1);
    check_val("set_235959", 32'(obs_vec()[33:10]), 32'h235959);
    step(1, 0, 0);
    check_val("back_to_run", 32'(bus.state), 32'd0);
    repeat (4) step(0, 0, 0);
    check_val("rollover_digits", 32'(obs_vec()[33:10]), 32'h000000);
    check_val("rollover_tick", 32'(bus.tick), 32'd1);

    // Pause at prescaler 2, resume
    while (m_presc != 2) step(0, 0, 0);
    step(0, 1, 0);
    check_val("pause_state", 32'(bus.state), 32'd1);
    digs = exp_vec()[33:10];
    repeat (20) step(0, 0, 0);
    check_val("pause_frozen", 32'(obs_vec()[33:10]), 32'(digs));
    step(0, 1, 0);
    check_val("resume_state", 32'(bus.state), 32'd0);
    step(0, 0, 0);
    check_val("resume_no_tick", 32'(bus.tick), 32'd0);
    step(0, 0, 0);
    check_val("resume_tick", 32'(bus.tick), 32'd1);

    // Minute wrap without carry, then 24 hour presses
    press(1, 0, 0);
    while (m_sec / 3600 != 0) press(0, 0, 1);
    press(1, 0, 0);
    while ((m_sec / 60) % 60 != 59) press(0, 0, 1);
    press(0, 0, 1);
    check_val("min_wrap", 32'({bus.cout4, bus.cout3}), 32'h00);
    check_val("min_wrap_hours", 32'({bus.cout6, bus.cout5}), 32'h00);
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    while (m_sec / 3600 != 7) press(0, 0, 1);
    h0 = bcd2(m_sec / 3600);
    repeat (24) press(0, 0, 1);
    check_val("hour_24_presses", 32'({bus.cout6, bus.cout5}), 32'(h0));

    // Blink in SET_SEC, then none in RUN
    press(1, 0, 0);
    press(1, 0, 0);
    check_val("in_set_sec", 32'(bus.state), 32'd4);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0);
      check_val("blink_sec", 32'(bus.blank), (m_presc >= 2) ? 32'h03 : 32'h00);
    end
    press(1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0);
      check_val("blank_run", 32'(bus.blank), 32'h00);
    end

    // Mode beats inc; held inc gives one increment
    while (m_presc == TD - 1) step(0, 0, 0);
    digs = exp_vec()[33:10];
    step(1, 0, 1);
    check_val("prio_state", 32'(bus.state), 32'd2);
    check_val("prio_digits", 32'(obs_vec()[33:10]), 32'(digs));
    step(0, 0, 0);
    h0 = bcd2(((m_sec / 3600) + 1) % 24);
    repeat (10) step(0, 0, 1);
    step(0, 0, 0);
    check_val("hold_inc_once", 32'({bus.cout6, bus.cout5}), 32'(h0));
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);

    // Random key traffic
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);

    // Asynchronous reset mid-count
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    bus.key_mode = 0; bus.key_run = 0; bus.key_inc = 0;
    @(posedge clk);
    #1;
    check_all("reset_held");
    rst = 1'b1;
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/digit_clock_ctrl.md
# digit_clock_ctrl

- Time-of-day controller for the six-digit seven-segment display path.
- Keeps an HH:MM:SS count as six BCD digits, advanced by an internal 1 Hz prescaler.
- Sequences run, pause and set modes from three key inputs.
- Feeds the per-digit BCD buses and a blank mask to the existing seven-segment decoders.

## Interface
- TICK_DIV, default 50000000: clk cycles per second; minimum 2; must be even.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- key_mode  in  1  level input, already synchronised and debounced; its rising edge advances the mode.
- key_run  in  1  level input, already synchronised and debounced; its rising edge toggles run/pause.
- key_inc  in  1  level input, already synchronised and debounced; its rising edge increments the selected field.
- cout1  out  4  BCD seconds ones.
- cout2  out  4  BCD seconds tens.
- cout3  out  4  BCD minutes ones.
- cout4  out  4  BCD minutes tens.
- cout5  out  4  BCD hours ones.
- cout6  out  4  BCD hours tens.
- blank  out  6  per-digit blank request; bit0 = cout1 … bit5 = cout6; 1 = decoder drives the digit dark.
- tick  out  1  one-cycle pulse, registered, on each time advance.
- state  out  3  current mode: RUN=0, PAUSE=1, SET_HOUR=2, SET_MIN=3, SET_SEC=4.

## Operation
- Reset values (rst low, asynchronous):
  - all couts = 0.
  - state = RUN.
  - prescaler = 0.
  - key history registers = 0.
  - tick = 0.
  - blank = 0.
- Edge detect:
  - press_x = key_x & ~key_x_q, where key_x_q is key_x registered each cycle.
  - A held key produces exactly one press.
- Key priority when presses coincide in one cycle: mode > run > inc. Only the highest-priority press acts; the others are discarded.
- Mode transitions:
  - RUN or PAUSE --mode--> SET_HOUR --mode--> SET_MIN --mode--> SET_SEC --mode--> RUN.
  - RUN --run--> PAUSE; PAUSE --run--> RUN.
  - run press is ignored in SET_* states.
- Prescaler:
  - Width $clog2(TICK_DIV).
  - RUN and SET_*: counts 0..TICK_DIV-1, then wraps to 0.
  - PAUSE: holds its value.
  - Cleared to 0 on every transition into SET_HOUR and into RUN from SET_SEC.
  - A RUN↔PAUSE toggle keeps the prescaler value.
- Time advance, RUN only, on the edge where prescaler == TICK_DIV-1:
  - Seconds increment with carry: ones 9→0 carries into tens, tens 5→0 carries into minutes.
  - Minutes use the same rule and carry into hours.
  - Hours run 00..23; 23:59:59 → 00:00:00.
  - tick = 1 in the following cycle.
- Set increment, inc press in SET_* only:
  - Selected field increments as a two-digit BCD value with no carry out.
  - SET_HOUR: 23 → 00.
  - SET_MIN / SET_SEC: 59 → 00.
  - Other fields unchanged.
  - The inc press also clears the prescaler so the field is shown immediately.
- Blink (registered blank):
  - Active only in SET_* states.
  - Bits of the selected field = (prescaler >= TICK_DIV/2):
    - SET_HOUR → bits 5:4.
    - SET_MIN → bits 3:2.
    - SET_SEC → bits 1:0.
  - All other bits are 0. blank = 0 in RUN and PAUSE.
- Digits never hold non-BCD values; a tens digit never exceeds its range (hours tens ≤ 2; minutes/seconds tens ≤ 5).

## Timing
- Key press at edge N (key_x high, key_x_q low): state or digit change is visible after edge N. Latency 1 cycle from the key level.
- Time advance every TICK_DIV cycles in uninterrupted RUN.
- First advance after entering RUN from SET_SEC occurs exactly TICK_DIV edges after the entering edge.
- tick is high for one cycle, one cycle after the digit update edge.
- Mode press on the same edge as a prescaler wrap in RUN:
  - Mode wins; no time advance.
  - Prescaler cleared.
- Reset asserted mid-count or mid-set: all outputs return to reset values immediately, without waiting for a clock edge.
- Release is sampled at the next clk edge.

## Test plan
- Reset/run, TICK_DIV=4:
  - Release rst, no keys.
  - After 4 edges, cout1=1 and tick pulses once.
  - After 40 edges, cout2:cout1 = 1,0.
- Rollover:
  - Set 23:59:59 via SET keys, then return to RUN.
  - After 4 edges, all couts = 0 and tick = 1.
- Pause:
  - Press run at prescaler=2: state=1; digits and prescaler frozen for 20 cycles.
  - Press run again: next advance after 2 more edges.
- Set wrap:
  - Enter SET_MIN at 00:59:xx; press inc once → minutes 00, hours still 00.
  - In SET_HOUR, 24 presses → hours back to the starting value.
- Blink:
  - In SET_SEC with TICK_DIV=4: blank = 6'b000011 while prescaler is 2–3, else 0.
  - blank = 0 in RUN.
- Priority/hold:
  - Assert key_mode and key_inc together in RUN → state=2, digits unchanged.
  - Hold key_inc high for 10 cycles in SET_HOUR → exactly one increment.
